// File: rtl/alu_add_and_flags_unit_if.sv
// Operand/result bus for the execute-stage ADD/AND ALU slice.
// The master issues operands and an opcode. The slave returns the registered
// result and the flags one cycle later.
interface alu_add_and_flags_unit_if;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [1:0]  op_size;
    logic        out_valid;
    logic [31:0] res;
    logic [5:0]  flags;

    modport master (
        output in_valid, a, b, op, op_size,
        input  out_valid, res, flags
    );

    modport slave (
        input  in_valid, a, b, op, op_size,
        output out_valid, res, flags
    );
endinterface

// File: rtl/alu_add_and_flags_unit.sv
// Registered ADD/AND ALU slice with x86-style status flags.
// Flag vector layout: [0]CF [1]PF [2]AF [3]ZF [4]SF [5]OF.
// Optional feature macro: ALU_SUB_EN. When it is defined, op=10 performs SUB.
// When it is not defined, op=10 is an ADD.
module alu_add_and_flags_unit (
    input  logic                        clk,
    input  logic                        rst,
    alu_add_and_flags_unit_if.slave     bus
);

    logic        is_and;
    logic        is_sub;
    logic [31:0] b_eff;
    logic [32:0] sum;
    logic [31:0] result;
    logic        carry_m;
    logic        msb_a;
    logic        msb_b;
    logic        msb_r;
    logic        zero_m;
    logic        af_raw;
    logic [5:0]  flags_next;

    // Operand conditioning and the single shared 33-bit adder; SUB reuses it as a + ~b + 1
    always_comb begin
        is_and = bus.op[0];
`ifdef ALU_SUB_EN
        is_sub = (bus.op == 2'b10);
`else
        is_sub = 1'b0;
`endif
        b_eff  = is_sub ? ~bus.b : bus.b;
        sum    = {1'b0, bus.a} + {1'b0, b_eff} + {32'd0, is_sub};
        result = is_and ? (bus.a & bus.b) : sum[31:0];
    end

    // Pick the size-dependent MSB, the carry out of that MSB and the zero test.
    // The carry out of bit 7 or 15 is recovered from the carry into bit 8 or 16 of the full sum.
    always_comb begin
        carry_m = 1'b0;
        msb_a   = 1'b0;
        msb_b   = 1'b0;
        msb_r   = 1'b0;
        zero_m  = 1'b0;
        case (bus.op_size)
            2'b00: begin
                carry_m = sum[8] ^ bus.a[8] ^ b_eff[8];
                msb_a   = bus.a[7];
                msb_b   = b_eff[7];
                msb_r   = result[7];
                zero_m  = (result[7:0] == 8'd0);
            end
            2'b01: begin
                carry_m = sum[16] ^ bus.a[16] ^ b_eff[16];
                msb_a   = bus.a[15];
                msb_b   = b_eff[15];
                msb_r   = result[15];
                zero_m  = (result[15:0] == 16'd0);
            end
            default: begin
                carry_m = sum[32];
                msb_a   = bus.a[31];
                msb_b   = b_eff[31];
                msb_r   = result[31];
                zero_m  = (result == 32'd0);
            end
        endcase
    end

    // Flag assembly. For SUB, CF and AF report a borrow, which is the inverted adder carry.
    // OF uses the conditioned operand, so one overflow expression covers both ADD and SUB.
    always_comb begin
        flags_next    = 6'd0;
        af_raw        = bus.a[4] ^ b_eff[4] ^ result[4];
        flags_next[1] = ~^result[7:0];
        flags_next[3] = zero_m;
        flags_next[4] = msb_r;
        if (!is_and) begin
            flags_next[0] = carry_m ^ is_sub;
            flags_next[2] = af_raw ^ is_sub;
            flags_next[5] = (msb_a == msb_b) && (msb_r != msb_a);
        end
    end

    // Output register: reset clears everything, a valid issue loads, otherwise res/flags hold
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.res       <= 32'd0;
            bus.flags     <= 6'd0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.res   <= result;
                bus.flags <= flags_next;
            end
        end
    end

endmodule

// File: tb/tb_alu_add_and_flags_unit.sv
// Directed self-checking bench for alu_add_and_flags_unit.
module tb_alu_add_and_flags_unit;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    alu_add_and_flags_unit_if bus ();

    alu_add_and_flags_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs on the falling edge, then step to 1ns past the next rising edge
    task automatic drive(input logic v, input logic [1:0] op, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.in_valid = v;
        bus.op       = op;
        bus.op_size  = sz;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        #1;
    endtask

    // Reset with a valid issue pending clears the outputs, and idle cycles then hold them
    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 2'b00, 2'b00, 32'h000000FF, 32'h00000001);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.res !== 32'd0 || bus.flags !== 6'd0) begin
            failures++;
            $display("[TB] FAIL reset_clear: got v=%b res=%h flags=%h, want v=0 res=0 flags=0",
                     bus.out_valid, bus.res, bus.flags);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 2'b01, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.res !== 32'd0 || bus.flags !== 6'd0) begin
                failures++;
                $display("[TB] FAIL reset_hold%0d: got v=%b res=%h flags=%h, want v=0 res=0 flags=0",
                         i, bus.out_valid, bus.res, bus.flags);
            end
        end
    endtask

    // A table of directed ADD/AND vectors with hand-computed results and flags
    task automatic test_ops();
        logic [1:0]  t_op  [10];
        logic [1:0]  t_sz  [10];
        logic [31:0] t_a   [10];
        logic [31:0] t_b   [10];
        logic [31:0] t_res [10];
        logic [5:0]  t_flg [10];
        t_op[0]=2'b00; t_sz[0]=2'b00; t_a[0]=32'h000000FF; t_b[0]=32'h00000001; t_res[0]=32'h00000100; t_flg[0]=6'h0F;
        t_op[1]=2'b00; t_sz[1]=2'b10; t_a[1]=32'h7FFFFFFF; t_b[1]=32'h00000001; t_res[1]=32'h80000000; t_flg[1]=6'h36;
        t_op[2]=2'b00; t_sz[2]=2'b01; t_a[2]=32'h0000FFFF; t_b[2]=32'h00000001; t_res[2]=32'h00010000; t_flg[2]=6'h0F;
        t_op[3]=2'b01; t_sz[3]=2'b01; t_a[3]=32'h1234F0F0; t_b[3]=32'h00008080; t_res[3]=32'h00008080; t_flg[3]=6'h10;
        t_op[4]=2'b01; t_sz[4]=2'b10; t_a[4]=32'hFFFF0000; t_b[4]=32'h0000FFFF; t_res[4]=32'h00000000; t_flg[4]=6'h0A;
        t_op[5]=2'b00; t_sz[5]=2'b11; t_a[5]=32'hFFFFFFFF; t_b[5]=32'h00000001; t_res[5]=32'h00000000; t_flg[5]=6'h0F;
        t_op[6]=2'b11; t_sz[6]=2'b00; t_a[6]=32'h000000FF; t_b[6]=32'h0000000F; t_res[6]=32'h0000000F; t_flg[6]=6'h02;
        t_op[7]=2'b00; t_sz[7]=2'b00; t_a[7]=32'h12340001; t_b[7]=32'h00000001; t_res[7]=32'h12340002; t_flg[7]=6'h00;
        t_op[8]=2'b01; t_sz[8]=2'b00; t_a[8]=32'hFFFFFF00; t_b[8]=32'hFFFFFFFF; t_res[8]=32'hFFFFFF00; t_flg[8]=6'h0A;
        t_op[9]=2'b00; t_sz[9]=2'b00; t_a[9]=32'h00000080; t_b[9]=32'h00000080; t_res[9]=32'h00000100; t_flg[9]=6'h2B;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, t_op[i], t_sz[i], t_a[i], t_b[i]);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.res !== t_res[i] || bus.flags !== t_flg[i]) begin
                failures++;
                $display("[TB] FAIL op_vec%0d: got v=%b res=%h flags=%h, want v=1 res=%h flags=%h",
                         i, bus.out_valid, bus.res, bus.flags, t_res[i], t_flg[i]);
            end
        end
    endtask

    // Without ALU_SUB_EN op=10 must add. With it, op=10 must subtract.
    task automatic test_op10();
`ifdef ALU_SUB_EN
        drive(1'b1, 2'b10, 2'b00, 32'h00000000, 32'h00000001);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.res !== 32'hFFFFFFFF || bus.flags !== 6'h17) begin
            failures++;
            $display("[TB] FAIL sub8: got v=%b res=%h flags=%h, want v=1 res=ffffffff flags=17",
                     bus.out_valid, bus.res, bus.flags);
        end
`else
        drive(1'b1, 2'b10, 2'b00, 32'h000000FF, 32'h00000001);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.res !== 32'h00000100 || bus.flags !== 6'h0F) begin
            failures++;
            $display("[TB] FAIL op10_as_add: got v=%b res=%h flags=%h, want v=1 res=00000100 flags=0f",
                     bus.out_valid, bus.res, bus.flags);
        end
`endif
    endtask

    // After a valid result, idle cycles with changing operands keep res/flags and drop out_valid
    task automatic test_hold();
        drive(1'b1, 2'b00, 2'b10, 32'h7FFFFFFF, 32'h00000001);
        drive(1'b0, 2'b01, 2'b00, 32'h00000000, 32'h00000000);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.res !== 32'h80000000 || bus.flags !== 6'h36) begin
            failures++;
            $display("[TB] FAIL hold: got v=%b res=%h flags=%h, want v=0 res=80000000 flags=36",
                     bus.out_valid, bus.res, bus.flags);
        end
    endtask

    // Consecutive issues every cycle, followed by a reset that clears non-zero outputs
    task automatic test_back_to_back();
        drive(1'b1, 2'b01, 2'b10, 32'hFFFF0000, 32'h0000FFFF);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.res !== 32'h00000000 || bus.flags !== 6'h0A) begin
            failures++;
            $display("[TB] FAIL b2b_0: got v=%b res=%h flags=%h, want v=1 res=00000000 flags=0a",
                     bus.out_valid, bus.res, bus.flags);
        end
        drive(1'b1, 2'b00, 2'b01, 32'h0000FFFF, 32'h00000001);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.res !== 32'h00010000 || bus.flags !== 6'h0F) begin
            failures++;
            $display("[TB] FAIL b2b_1: got v=%b res=%h flags=%h, want v=1 res=00010000 flags=0f",
                     bus.out_valid, bus.res, bus.flags);
        end
        rst = 1'b1;
        drive(1'b1, 2'b00, 2'b10, 32'h7FFFFFFF, 32'h00000001);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.res !== 32'd0 || bus.flags !== 6'd0) begin
            failures++;
            $display("[TB] FAIL b2b_reset: got v=%b res=%h flags=%h, want v=0 res=0 flags=0",
                     bus.out_valid, bus.res, bus.flags);
        end
        rst = 1'b0;
    endtask

    // Test sequence
    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.op       = 2'b00;
        bus.op_size  = 2'b00;
        bus.a        = 32'd0;
        bus.b        = 32'd0;
        test_reset();
        test_ops();
        test_op10();
        test_hold();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
